// File: rtl/mips_wbuf_pkg.sv
// Shared definitions for the MIPS store write buffer: entry field widths and
// the byte-lane merge used wherever buffered bytes overlay a word.
package mips_wbuf_pkg;

    localparam int ADDR_W = 30;
    localparam int MASK_W = 4;
    localparam int DATA_W = 32;
    localparam int LANE_W = DATA_W / MASK_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [MASK_W-1:0] mask;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    // Lane i of the result comes from data when mask[i] is set, else from base.
    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] base,
        input logic [MASK_W-1:0] mask,
        input logic [DATA_W-1:0] data
    );
        logic [DATA_W-1:0] merged;
        merged = base;
        for (int i = 0; i < MASK_W; i++) begin
            if (mask[i]) merged[i*LANE_W +: LANE_W] = data[i*LANE_W +: LANE_W];
        end
        return merged;
    endfunction

endpackage

// File: rtl/mips_wbuf_merge.sv
// Combinational byte-lane merge: masked lanes of i_data overlay i_base.
module mips_wbuf_merge
    import mips_wbuf_pkg::*;
(
    input  logic [DATA_W-1:0] i_base,
    input  logic [MASK_W-1:0] i_mask,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_word
);

    assign o_word = lane_merge(i_base, i_mask, i_data);

endmodule

// File: rtl/mips_wbuf.sv
// Store write buffer between the MIPS I data port and memory: one-cycle store
// retire into a coalescing FIFO, valid/ready drain, and combinational load forwarding.
module mips_wbuf
    import mips_wbuf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] DA,
    input  logic [3:0]  we,
    input  logic [31:0] DO,
    input  logic        re,
    output logic [31:0] DI,
    output logic [31:0] MA,
    input  logic [31:0] MI,
    output logic        WV,
    input  logic        WR,
    output logic [31:0] WA,
    output logic [3:0]  WM,
    output logic [31:0] WD,
    output logic        full,
    output logic        empty,
    output logic        ovf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [MASK_W-1:0] r_mask [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [AW:0]       r_count;
    logic              r_ovf;

    logic [ADDR_W-1:0] w_word;
    logic [AW-1:0]     w_young;
    logic              w_pop;
    logic              w_store;
    logic              w_coalesce;
    logic              w_push;
    logic [DATA_W-1:0] w_coal_data;
    logic              w_unused;

    assign w_unused = &{1'b0, re, DA[1:0]};

    assign w_word  = DA[31:2];
    assign w_young = r_tail - AW'(1);
    assign w_pop   = WV && WR;
    assign w_store = |we;

    // The youngest entry may absorb the store unless it is leaving this very edge.
    assign w_coalesce = w_store && (r_count != '0) && (r_addr[w_young] == w_word)
                        && !(w_pop && (r_count == ONE_CNT));
    assign w_push     = w_store && !w_coalesce && ((r_count != FULL_CNT) || w_pop);

    mips_wbuf_merge u_coalesce (
        .i_base (r_data[w_young]),
        .i_mask (we),
        .i_data (DO),
        .o_word (w_coal_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mask[i] <= '0;
        end else begin
            if (w_pop)  r_head <= r_head + AW'(1);
            if (w_push) r_tail <= r_tail + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + ONE_CNT;
            else if (!w_push && w_pop) r_count <= r_count - ONE_CNT;
            if (w_store && !w_coalesce && !w_push) r_ovf <= 1'b1;
            if (w_push)          r_mask[r_tail]  <= we;
            else if (w_coalesce) r_mask[w_young] <= r_mask[w_young] | we;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_addr[r_tail] <= w_word;
            r_data[r_tail] <= DO;
        end else if (w_coalesce) begin
            r_data[w_young] <= w_coal_data;
        end
    end

    // Forwarding chain, oldest entry first so the youngest store wins per byte.
    for (genvar g = 0; g < DEPTH; g++) begin : g_fwd
        logic [AW-1:0]     w_idx;
        logic              w_hit;
        logic [DATA_W-1:0] w_in;
        logic [DATA_W-1:0] w_out;

        assign w_idx = r_head + AW'(g);
        assign w_hit = ((AW+1)'(g) < r_count) && (r_addr[w_idx] == w_word);

        if (g == 0) begin : g_first
            assign w_in = MI;
        end else begin : g_next
            assign w_in = g_fwd[g-1].w_out;
        end

        mips_wbuf_merge u_merge (
            .i_base (w_in),
            .i_mask (w_hit ? r_mask[w_idx] : '0),
            .i_data (r_data[w_idx]),
            .o_word (w_out)
        );
    end

    assign DI    = g_fwd[DEPTH-1].w_out;
    assign MA    = {DA[31:2], 2'b00};
    assign WV    = (r_count != '0);
    assign WA    = {r_addr[r_head], 2'b00};
    assign WM    = r_mask[r_head];
    assign WD    = r_data[r_head];
    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_mips_wbuf.sv
// Directed and model-based bench for mips_wbuf with a word-addressed memory behind the write channel.
module tb_mips_wbuf;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] DA;
    logic [3:0]  we;
    logic [31:0] DO;
    logic        re;
    logic [31:0] DI;
    logic [31:0] MA;
    logic [31:0] MI;
    logic        WV;
    logic        WR;
    logic [31:0] WA;
    logic [3:0]  WM;
    logic [31:0] WD;
    logic        full;
    logic        empty;
    logic        ovf;

    logic [31:0] mem [0:255];
    logic        mem_clr;
    logic        mi_force;
    logic [31:0] mi_val;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mips_wbuf dut (
        .clock (clock), .reset (reset),
        .DA (DA), .we (we), .DO (DO), .re (re), .DI (DI),
        .MA (MA), .MI (MI),
        .WV (WV), .WR (WR), .WA (WA), .WM (WM), .WD (WD),
        .full (full), .empty (empty), .ovf (ovf)
    );

    assign MI = mi_force ? mi_val : mem[MA[9:2]];

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (WV && WR) begin
            for (int b = 0; b < 4; b++)
                if (WM[b]) mem[WA[9:2]][b*8 +: 8] <= WD[b*8 +: 8];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        DA = a; we = m; DO = d;
        step();
        we = 4'h0;
    endtask

    task automatic apply_reset(input logic clr);
        reset = 1'b1; we = 4'h0; WR = 1'b0; mem_clr = clr;
        step();
        step();
        reset = 1'b0; mem_clr = 1'b0;
    endtask

    task automatic test_reset();
        WR = 1'b0;
        store(32'h200, 4'hF, 32'hFFFF_FFFF);
        store(32'h204, 4'hF, 32'hFFFF_FFFF);
        store(32'h208, 4'hF, 32'hFFFF_FFFF);
        #2;
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL rst_pre_empty: got %b expected 0", empty); end
        reset = 1'b1; WR = 1'b1;
        #1;
        n_cmp++; if (WV !== 1'b0) begin n_err++; $display("FAIL rst_async_wv: got %b expected 0", WV); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_async_empty: got %b expected 1", empty); end
        step();
        reset = 1'b0;
        mi_force = 1'b1; mi_val = 32'h1122_3344; re = 1'b1; DA = 32'h200;
        #2;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b expected 1", empty); end
        n_cmp++; if (WV !== 1'b0) begin n_err++; $display("FAIL rst_wv: got %b expected 0", WV); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", ovf); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b expected 0", full); end
        n_cmp++; if (DI !== 32'h1122_3344) begin n_err++; $display("FAIL rst_di: got %h expected 11223344", DI); end
        n_cmp++; if (mem[8'h80] !== 32'h0) begin n_err++; $display("FAIL rst_no_write: got %h expected 00000000", mem[8'h80]); end
        mi_force = 1'b0; WR = 1'b0;
    endtask

    task automatic test_coalesce();
        WR = 1'b0;
        store(32'h100, 4'b0001, 32'h0000_00AA);
        store(32'h100, 4'b0100, 32'h00BB_0000);
        mi_force = 1'b1; mi_val = 32'h5566_7788; re = 1'b1; DA = 32'h100;
        #2;
        n_cmp++; if (DI !== 32'h55BB_77AA) begin n_err++; $display("FAIL coal_di: got %h expected 55bb77aa", DI); end
        n_cmp++; if (WA !== 32'h100) begin n_err++; $display("FAIL coal_wa: got %h expected 00000100", WA); end
        n_cmp++; if (WM !== 4'b0101) begin n_err++; $display("FAIL coal_wm: got %b expected 0101", WM); end
        n_cmp++; if (WD !== 32'h00BB_00AA) begin n_err++; $display("FAIL coal_wd: got %h expected 00bb00aa", WD); end
        mi_force = 1'b0; WR = 1'b1;
        step();
        WR = 1'b0;
        #2;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL coal_one_entry: empty got %b expected 1", empty); end
        n_cmp++; if (DI !== 32'h00BB_00AA) begin n_err++; $display("FAIL coal_mem: got %h expected 00bb00aa", DI); end
    endtask

    task automatic test_overflow();
        WR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL ovf_full_early[%0d]: got %b expected 0", i, full); end
            store(32'(i*4), 4'hF, 32'(i+1));
        end
        #2;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", full); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b expected 0", ovf); end
        store(32'h10, 4'hF, 32'h5);
        #2;
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", ovf); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_count4: full got %b expected 1", full); end
        WR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (WA !== 32'(i*4)) begin n_err++; $display("FAIL drain_wa[%0d]: got %h expected %h", i, WA, 32'(i*4)); end
            step();
            #2;
        end
        WR = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b expected 1", empty); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (mem[i] !== 32'(i+1)) begin n_err++; $display("FAIL drain_mem[%0d]: got %h expected %h", i, mem[i], 32'(i+1)); end
        end
        DA = 32'h10; re = 1'b1;
        #1;
        n_cmp++; if (DI !== 32'h0) begin n_err++; $display("FAIL dropped_store: got %h expected 00000000", DI); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_wa [4];
        exp_wa[0] = 32'h4; exp_wa[1] = 32'h8; exp_wa[2] = 32'hC; exp_wa[3] = 32'h20;
        apply_reset(1'b0);
        for (int i = 0; i < 4; i++) store(32'(i*4), 4'hF, 32'(32'h100 + i));
        DA = 32'h20; we = 4'hF; DO = 32'hCAFE_F00D; WR = 1'b1;
        #2;
        n_cmp++; if (WA !== 32'h0) begin n_err++; $display("FAIL pp_head: got %h expected 00000000", WA); end
        step();
        we = 4'h0;
        #2;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL pp_full: got %b expected 1", full); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL pp_ovf: got %b expected 0", ovf); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (WA !== exp_wa[i]) begin n_err++; $display("FAIL pp_wa[%0d]: got %h expected %h", i, WA, exp_wa[i]); end
            step();
            #2;
        end
        WR = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL pp_empty: got %b expected 1", empty); end
        n_cmp++; if (mem[8] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL pp_mem20: got %h expected cafef00d", mem[8]); end
    endtask

    task automatic test_pop_no_coalesce();
        WR = 1'b0;
        store(32'h40, 4'hF, 32'hDEAD_BEEF);
        DA = 32'h40; we = 4'b0011; DO = 32'h0000_CAFE; WR = 1'b1; re = 1'b1;
        #2;
        n_cmp++; if (DI !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL popfwd_di: got %h expected deadbeef", DI); end
        step();
        we = 4'h0;
        #2;
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL popnc_alloc: empty got %b expected 0", empty); end
        n_cmp++; if (WM !== 4'b0011) begin n_err++; $display("FAIL popnc_wm: got %b expected 0011", WM); end
        n_cmp++; if (WD[15:0] !== 16'hCAFE) begin n_err++; $display("FAIL popnc_wd: got %h expected cafe", WD[15:0]); end
        step();
        WR = 1'b0;
        #2;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL popnc_empty: got %b expected 1", empty); end
        n_cmp++; if (DI !== 32'hDEAD_CAFE) begin n_err++; $display("FAIL popnc_mem: got %h expected deadcafe", DI); end
    endtask

    task automatic test_random();
        logic [31:0] ref_w [8];
        logic [29:0] q [$];
        logic        m_ovf;
        logic        pop, co, push;
        int          widx;
        int          guard;
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) ref_w[i] = '0;
        m_ovf = 1'b0;
        re = 1'b1;
        for (int c = 0; c < 300; c++) begin
            WR = 1'($urandom_range(0, 1));
            DA = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            we = ($urandom_range(0, 9) < 6) ? 4'($urandom_range(1, 15)) : 4'h0;
            DO = $urandom;
            #2;
            widx = int'(DA[4:2]);
            n_cmp++; if (DI !== ref_w[widx]) begin n_err++; $display("FAIL rnd_di[%0d]: got %h expected %h", c, DI, ref_w[widx]); end
            n_cmp++; if (WV !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_wv[%0d]: got %b expected %b", c, WV, q.size() != 0); end
            if (q.size() != 0) begin
                n_cmp++; if (WA !== {q[0], 2'b00}) begin n_err++; $display("FAIL rnd_wa[%0d]: got %h expected %h", c, WA, {q[0], 2'b00}); end
            end
            n_cmp++; if (ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf[%0d]: got %b expected %b", c, ovf, m_ovf); end
            pop  = (q.size() != 0) && WR;
            co   = (we != 0) && (q.size() > 0) && (q[$] == DA[31:2]) && !(pop && q.size() == 1);
            push = (we != 0) && !co && ((q.size() < 4) || pop);
            if ((we != 0) && !co && !push) m_ovf = 1'b1;
            if (co || push)
                for (int b = 0; b < 4; b++)
                    if (we[b]) ref_w[widx][b*8 +: 8] = DO[b*8 +: 8];
            if (pop) void'(q.pop_front());
            if (push) q.push_back(DA[31:2]);
            step();
        end
        we = 4'h0; WR = 1'b1;
        guard = 0;
        while (empty !== 1'b1 && guard < 8) begin
            step();
            guard++;
        end
        step();
        WR = 1'b0;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rnd_drain: empty got %b expected 1", empty); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (mem[i] !== ref_w[i]) begin n_err++; $display("FAIL rnd_mem[%0d]: got %h expected %h", i, mem[i], ref_w[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; DA = '0; we = '0; DO = '0; re = 1'b0; WR = 1'b0;
        mi_force = 1'b0; mi_val = '0; mem_clr = 1'b1;
        step();
        step();
        reset = 1'b0; mem_clr = 1'b0;
        test_reset();
        test_coalesce();
        test_overflow();
        test_full_push_pop();
        test_pop_no_coalesce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
